// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit-side blocks.
//   arb_state_t : state encoding of the transmit arbiter
//   CNT_W       : width of the timeout and gap counters
package uart_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin priority encoder.
// Ports:
//   req        in  : request vector, one bit per requester
//   last_grant in  : index of the previous winner
//   pick_id    out : first requester found searching upward from last_grant+1, wrapping
//   pick_valid out : at least one request is set
module rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last_grant,
  output logic [$clog2(NUM_SRC)-1:0] pick_id,
  output logic                       pick_valid
);

  localparam int ID_W = $clog2(NUM_SRC);

  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;
  logic            hi_valid;
  logic            lo_valid;

  // Requesters above last_grant beat those at or below it; within each half
  // the lowest index wins, so scanning downward leaves the lowest one behind.
  always_comb begin
    hi_id    = '0;
    lo_id    = '0;
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (i > int'(last_grant)) begin
          hi_id    = ID_W'(i);
          hi_valid = 1'b1;
        end else begin
          lo_id    = ID_W'(i);
          lo_valid = 1'b1;
        end
      end
    end
  end

  assign pick_valid = hi_valid | lo_valid;
  assign pick_id    = hi_valid ? hi_id : lo_id;

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares the uart_duplex transmitter between NUM_SRC byte-stream sources.
// A source owns the transmitter for a whole message (through the byte flagged
// last); owners rotate round-robin, with GAP_CYCLES idle cycles after each one.
// Ports:
//   ifclk, resetb      : clock, asynchronous active-low reset
//   src_valid/data/last: per-source byte offer (byte i at src_data[8i+7:8i])
//   src_ready          : one-cycle accept pulse to the owner
//   uart_tx_data/we    : to uart_duplex tx_data / we
//   tx_busy, tx_done   : from uart_duplex
//   grant_valid/id     : current (or last) owner
//   timeout_err        : one-cycle pulse when an idle owner loses the grant
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_SRC        = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       ifclk,
  input  logic                       resetb,
  input  logic [NUM_SRC-1:0]         src_valid,
  input  logic [8*NUM_SRC-1:0]       src_data,
  input  logic [NUM_SRC-1:0]         src_last,
  output logic [NUM_SRC-1:0]         src_ready,
  output logic [7:0]                 uart_tx_data,
  output logic                       uart_we,
  input  logic                       tx_busy,
  input  logic                       tx_done,
  output logic                       grant_valid,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int ID_W = $clog2(NUM_SRC);

  // GAP always lasts at least one cycle, even with GAP_CYCLES = 0.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [ID_W-1:0]  last_grant;
  logic             last_q;
  logic [CNT_W-1:0] to_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [ID_W-1:0]  pick_id;
  logic             pick_valid;
  logic             fire;
  logic             to_hit;
  logic             gap_end;
  logic [7:0]       src_bytes [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_bytes
    assign src_bytes[i] = src_data[8*i +: 8];
  end

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req        (src_valid),
    .last_grant (last_grant),
    .pick_id    (pick_id),
    .pick_valid (pick_valid)
  );

  assign uart_tx_data = grant_valid ? src_bytes[grant_id] : 8'h00;

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The timeout check takes precedence over a byte offered in the same cycle:
  // once the limit is reached the grant is gone.
  always_comb begin
    state_next  = state;
    uart_we     = 1'b0;
    src_ready   = '0;
    timeout_err = 1'b0;
    fire        = 1'b0;
    to_hit      = 1'b0;
    gap_end     = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (to_cnt == TO_LIMIT) begin
          to_hit      = 1'b1;
          timeout_err = 1'b1;
          state_next  = GAP;
        end else if (src_valid[grant_id] && !tx_busy) begin
          fire                = 1'b1;
          uart_we             = 1'b1;
          src_ready[grant_id] = 1'b1;
          state_next          = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) begin
          state_next = last_q ? GAP : ISSUE;
        end
      end
      GAP: begin
        if (gap_cnt >= GAP_LAST) begin
          gap_end    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last_grant  <= ID_W'(NUM_SRC - 1);
      last_q      <= 1'b0;
      to_cnt      <= '0;
      gap_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id    <= pick_id;
            last_grant  <= pick_id;
            grant_valid <= 1'b1;
            to_cnt      <= '0;
          end
        end
        ISSUE: begin
          if (to_hit) begin
            grant_valid <= 1'b0;
            gap_cnt     <= '0;
          end else if (fire) begin
            last_q <= src_last[grant_id];
            to_cnt <= '0;
          end else if (!src_valid[grant_id]) begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            if (last_q) begin
              grant_valid <= 1'b0;
              gap_cnt     <= '0;
            end else begin
              to_cnt <= '0;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_end ? '0 : gap_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
